// File: rtl/ctrl_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : ctrl_seq_unit
// Brief    : Instruction control sequencer. It decodes single-cycle ops and
//            runs CALL/RET through the MEM and WB phases. Optional macro:
//            CTRL_SEQ_ILLEGAL_TRAP_EN (an illegal opcode halts the unit and
//            illegal_op stays set).
// Revision : 1.0 - initial release
// ============================================================================
module ctrl_seq_unit #(
    parameter int INSTR_W = 16,
    parameter int MEM_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               instr_valid,
    input  logic [INSTR_W-1:0] instr,
    output logic               instr_ready,
    input  logic               stall,
    input  logic               flush,
    output logic               ctrl_valid,
    output logic               data_reg,
    output logic               stack_reg,
    output logic               call,
    output logic               rtrn,
    output logic               branch,
    output logic               mem_to_reg,
    output logic               alu_src,
    output logic               sign_ext_sel,
    output logic               reg_rt_src,
    output logic               RegWrite,
    output logic               MemWrite,
    output logic               MemRead,
    output logic               load_half,
    output logic               half_spec,
    output logic [2:0]         alu_op,
    output logic               halted,
    output logic               illegal_op
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_MEM    = 2'd1;
    localparam logic [1:0] c_WB     = 2'd2;
    localparam logic [1:0] c_HALTED = 2'd3;

    localparam logic [1:0] c_CNT_INIT = 2'(MEM_LAT - 1);

`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
    localparam logic c_TRAP_EN = 1'b1;
`else
    localparam logic c_TRAP_EN = 1'b0;
`endif

    // Bundle bit positions, MSB first in port order.
    localparam logic [13:0] c_B_DATA_REG   = 14'h2000;
    localparam logic [13:0] c_B_STACK_REG  = 14'h1000;
    localparam logic [13:0] c_B_CALL       = 14'h0800;
    localparam logic [13:0] c_B_RTRN       = 14'h0400;
    localparam logic [13:0] c_B_BRANCH     = 14'h0200;
    localparam logic [13:0] c_B_MEM_TO_REG = 14'h0100;
    localparam logic [13:0] c_B_ALU_SRC    = 14'h0080;
    localparam logic [13:0] c_B_SIGN_EXT   = 14'h0040;
    localparam logic [13:0] c_B_REG_RT_SRC = 14'h0020;
    localparam logic [13:0] c_B_REG_WRITE  = 14'h0010;
    localparam logic [13:0] c_B_MEM_WRITE  = 14'h0008;
    localparam logic [13:0] c_B_MEM_READ   = 14'h0004;
    localparam logic [13:0] c_B_LOAD_HALF  = 14'h0002;
    localparam logic [13:0] c_B_HALF_SPEC  = 14'h0001;

    logic [1:0]  r_state, w_nxt_state;
    logic [1:0]  r_cnt, w_nxt_cnt;
    logic        r_is_ret, w_nxt_is_ret;
    logic        r_valid, w_nxt_valid;
    logic [13:0] r_bundle, w_nxt_bundle;
    logic [2:0]  r_alu, w_nxt_alu;
    logic        r_halted, w_nxt_halted;
    logic        r_illegal, w_nxt_illegal;

    logic [3:0]  w_opcode;
    logic        w_all_ones;
    logic [13:0] w_dec_bundle;
    logic [2:0]  w_dec_alu;
    logic [13:0] w_mem_bundle;
    logic [13:0] w_wb_bundle;

    assign w_opcode   = instr[INSTR_W-1 -: 4];
    assign w_all_ones = &instr;

    assign instr_ready = (r_state == c_IDLE) & ~stall & ~r_halted & ~flush;

    assign w_mem_bundle = c_B_STACK_REG | (r_is_ret ? c_B_MEM_READ : c_B_MEM_WRITE);
    assign w_wb_bundle  = c_B_STACK_REG | c_B_REG_WRITE | (r_is_ret ? c_B_RTRN : c_B_CALL);

    always_comb begin
        w_dec_bundle = '0;
        w_dec_alu    = 3'b000;
        case (w_opcode)
            4'h0, 4'h1, 4'h2, 4'h3, 4'h5, 4'h6, 4'h7: begin
                w_dec_bundle = c_B_REG_WRITE;
                w_dec_alu    = w_opcode[2:0];
            end
            4'h4: begin
                w_dec_bundle = c_B_REG_WRITE | c_B_ALU_SRC;
                w_dec_alu    = w_opcode[2:0];
            end
            4'h8: w_dec_bundle = c_B_DATA_REG | c_B_MEM_TO_REG | c_B_ALU_SRC |
                                 c_B_SIGN_EXT | c_B_REG_WRITE | c_B_MEM_READ;
            4'h9: w_dec_bundle = c_B_DATA_REG | c_B_ALU_SRC | c_B_SIGN_EXT |
                                 c_B_REG_RT_SRC | c_B_MEM_WRITE;
            4'hA, 4'hB: begin
                w_dec_bundle = c_B_REG_RT_SRC | c_B_REG_WRITE | c_B_LOAD_HALF |
                               (w_opcode[0] ? c_B_HALF_SPEC : 14'h0000);
                w_dec_alu    = w_opcode[2:0];
            end
            4'hC: w_dec_bundle = c_B_BRANCH | c_B_SIGN_EXT;
            default: ;
        endcase
    end

    always_comb begin
        w_nxt_state   = r_state;
        w_nxt_cnt     = r_cnt;
        w_nxt_is_ret  = r_is_ret;
        w_nxt_valid   = r_valid;
        w_nxt_bundle  = r_bundle;
        w_nxt_alu     = r_alu;
        w_nxt_halted  = r_halted;
        w_nxt_illegal = r_illegal;

        // HALTED is terminal and ignores flush/stall; its first cycle is the
        // HALT (or trapped op) ctrl_valid cycle, after which the bundle clears.
        if (r_state == c_HALTED) begin
            w_nxt_valid  = 1'b0;
            w_nxt_bundle = '0;
            w_nxt_alu    = 3'b000;
            w_nxt_halted = 1'b1;
        end else if (flush) begin
            w_nxt_state   = c_IDLE;
            w_nxt_cnt     = 2'd0;
            w_nxt_valid   = 1'b0;
            w_nxt_bundle  = '0;
            w_nxt_alu     = 3'b000;
            w_nxt_illegal = 1'b0;
        end else if (!stall) begin
            case (r_state)
                c_IDLE: begin
                    w_nxt_valid   = 1'b0;
                    w_nxt_bundle  = '0;
                    w_nxt_alu     = 3'b000;
                    w_nxt_illegal = 1'b0;
                    if (instr_valid) begin
                        w_nxt_valid = 1'b1;
                        if (w_opcode == 4'hD || w_opcode == 4'hE) begin
                            w_nxt_state  = c_MEM;
                            w_nxt_cnt    = c_CNT_INIT;
                            w_nxt_is_ret = (w_opcode == 4'hE);
                            w_nxt_bundle = c_B_STACK_REG |
                                           ((w_opcode == 4'hE) ? c_B_MEM_READ : c_B_MEM_WRITE);
                        end else if (w_opcode == 4'hF) begin
                            if (w_all_ones) begin
                                w_nxt_state = c_HALTED;
                            end else begin
                                w_nxt_illegal = 1'b1;
                                if (c_TRAP_EN) w_nxt_state = c_HALTED;
                            end
                        end else begin
                            w_nxt_bundle = w_dec_bundle;
                            w_nxt_alu    = w_dec_alu;
                        end
                    end
                end
                c_MEM: begin
                    if (r_cnt == 2'd0) begin
                        w_nxt_state  = c_WB;
                        w_nxt_bundle = w_wb_bundle;
                    end else begin
                        w_nxt_cnt    = r_cnt - 2'd1;
                        w_nxt_bundle = w_mem_bundle;
                    end
                end
                default: begin
                    w_nxt_state  = c_IDLE;
                    w_nxt_valid  = 1'b0;
                    w_nxt_bundle = '0;
                    w_nxt_alu    = 3'b000;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_cnt     <= 2'd0;
            r_is_ret  <= 1'b0;
            r_valid   <= 1'b0;
            r_bundle  <= '0;
            r_alu     <= 3'b000;
            r_halted  <= 1'b0;
            r_illegal <= 1'b0;
        end else begin
            r_state   <= w_nxt_state;
            r_cnt     <= w_nxt_cnt;
            r_is_ret  <= w_nxt_is_ret;
            r_valid   <= w_nxt_valid;
            r_bundle  <= w_nxt_bundle;
            r_alu     <= w_nxt_alu;
            r_halted  <= w_nxt_halted;
            r_illegal <= w_nxt_illegal;
        end
    end

    assign ctrl_valid = r_valid;
    assign {data_reg, stack_reg, call, rtrn, branch, mem_to_reg, alu_src,
            sign_ext_sel, reg_rt_src, RegWrite, MemWrite, MemRead,
            load_half, half_spec} = r_bundle;
    assign alu_op     = r_alu;
    assign halted     = r_halted;
    assign illegal_op = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_ctrl_seq_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ctrl_seq_unit
// Brief    : Directed and random stimulus for ctrl_seq_unit, compared against
//            a frame-queue reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ctrl_seq_unit;

    localparam int c_W       = 16;
    localparam int c_MEM_LAT = 3;

    localparam logic [13:0] c_DATA_REG   = 14'h2000;
    localparam logic [13:0] c_STACK_REG  = 14'h1000;
    localparam logic [13:0] c_CALL       = 14'h0800;
    localparam logic [13:0] c_RTRN       = 14'h0400;
    localparam logic [13:0] c_BRANCH     = 14'h0200;
    localparam logic [13:0] c_MEM_TO_REG = 14'h0100;
    localparam logic [13:0] c_ALU_SRC    = 14'h0080;
    localparam logic [13:0] c_SIGN_EXT   = 14'h0040;
    localparam logic [13:0] c_REG_RT_SRC = 14'h0020;
    localparam logic [13:0] c_REG_WRITE  = 14'h0010;
    localparam logic [13:0] c_MEM_WRITE  = 14'h0008;
    localparam logic [13:0] c_MEM_READ   = 14'h0004;
    localparam logic [13:0] c_LOAD_HALF  = 14'h0002;
    localparam logic [13:0] c_HALF_SPEC  = 14'h0001;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic instr_valid = 1'b0;
    logic [c_W-1:0] instr = '0;
    logic stall = 1'b0;
    logic flush = 1'b0;
    logic instr_ready, ctrl_valid;
    logic data_reg, stack_reg, call, rtrn, branch, mem_to_reg, alu_src;
    logic sign_ext_sel, reg_rt_src, RegWrite, MemWrite, MemRead, load_half, half_spec;
    logic [2:0] alu_op;
    logic halted, illegal_op;

    always #5 clk = ~clk;

    ctrl_seq_unit #(.INSTR_W(c_W), .MEM_LAT(c_MEM_LAT)) u_dut (
        .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr(instr),
        .instr_ready(instr_ready), .stall(stall), .flush(flush),
        .ctrl_valid(ctrl_valid), .data_reg(data_reg), .stack_reg(stack_reg),
        .call(call), .rtrn(rtrn), .branch(branch), .mem_to_reg(mem_to_reg),
        .alu_src(alu_src), .sign_ext_sel(sign_ext_sel), .reg_rt_src(reg_rt_src),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .MemRead(MemRead),
        .load_half(load_half), .half_spec(half_spec), .alu_op(alu_op),
        .halted(halted), .illegal_op(illegal_op)
    );

    // One frame is what the outputs show for one cycle.
    typedef struct packed {
        logic        valid;
        logic [13:0] b;
        logic [2:0]  alu;
        logic        halted;
        logic        illegal;
        logic        blocks;
    } frame_t;

    frame_t m_cur;
    frame_t m_q[$];
    bit     m_halting;
    int     n_cmp = 0;
    int     n_fail = 0;

    logic [19:0] w_obs;
    assign w_obs = {ctrl_valid, data_reg, stack_reg, call, rtrn, branch, mem_to_reg,
                    alu_src, sign_ext_sel, reg_rt_src, RegWrite, MemWrite, MemRead,
                    load_half, half_spec, alu_op, halted, illegal_op};

    function automatic frame_t mk(logic [13:0] b, logic [2:0] alu, logic blk, logic ill);
        frame_t f;
        f = '0;
        f.valid = 1'b1; f.b = b; f.alu = alu; f.blocks = blk; f.illegal = ill;
        return f;
    endfunction

    function automatic logic model_ready(logic st, logic fl);
        return !m_halting && !m_cur.blocks && (m_q.size() == 0) && !st && !fl;
    endfunction

    task automatic chk(input string tag, input logic [19:0] obs, input logic [19:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_accept(input logic [c_W-1:0] ins);
        logic [3:0] op;
        op = ins[c_W-1 -: 4];
        m_q.delete();
        if (&ins) begin
            m_cur = mk(14'h0, 3'b000, 1'b1, 1'b0);
            m_halting = 1'b1;
        end else if (op == 4'hF) begin
            m_cur = mk(14'h0, 3'b000, 1'b0, 1'b1);
`ifdef CTRL_SEQ_ILLEGAL_TRAP_EN
            m_halting = 1'b1;
`endif
        end else if (op == 4'hD || op == 4'hE) begin
            for (int i = 0; i < c_MEM_LAT; i++)
                m_q.push_back(mk(c_STACK_REG | (op == 4'hE ? c_MEM_READ : c_MEM_WRITE),
                                 3'b000, 1'b1, 1'b0));
            m_q.push_back(mk(c_STACK_REG | c_REG_WRITE | (op == 4'hE ? c_RTRN : c_CALL),
                             3'b000, 1'b1, 1'b0));
            m_cur = m_q.pop_front();
        end else begin
            case (op)
                4'h4:    m_cur = mk(c_REG_WRITE | c_ALU_SRC, 3'd4, 1'b0, 1'b0);
                4'h8:    m_cur = mk(c_DATA_REG | c_MEM_TO_REG | c_ALU_SRC | c_SIGN_EXT |
                                    c_REG_WRITE | c_MEM_READ, 3'b000, 1'b0, 1'b0);
                4'h9:    m_cur = mk(c_DATA_REG | c_ALU_SRC | c_SIGN_EXT | c_REG_RT_SRC |
                                    c_MEM_WRITE, 3'b000, 1'b0, 1'b0);
                4'hA:    m_cur = mk(c_REG_RT_SRC | c_REG_WRITE | c_LOAD_HALF, 3'd2, 1'b0, 1'b0);
                4'hB:    m_cur = mk(c_REG_RT_SRC | c_REG_WRITE | c_LOAD_HALF | c_HALF_SPEC,
                                    3'd3, 1'b0, 1'b0);
                4'hC:    m_cur = mk(c_BRANCH | c_SIGN_EXT, 3'b000, 1'b0, 1'b0);
                default: m_cur = mk(c_REG_WRITE, op[2:0], 1'b0, 1'b0);
            endcase
        end
    endtask

    task automatic model_edge(input logic v, input logic [c_W-1:0] ins,
                              input logic st, input logic fl);
        logic rdy;
        rdy = model_ready(st, fl);
        if (m_halting) begin
            if (!m_cur.halted) begin
                logic ill;
                ill = m_cur.illegal;
                m_cur = '0;
                m_cur.halted = 1'b1; m_cur.illegal = ill; m_cur.blocks = 1'b1;
            end
        end else if (fl) begin
            m_q.delete();
            m_cur = '0;
        end else if (st) begin
            // hold everything
        end else if (v && rdy) begin
            model_accept(ins);
        end else if (m_q.size() > 0) begin
            m_cur = m_q.pop_front();
        end else begin
            m_cur = '0;
        end
    endtask

    // Called one time unit after a rising edge; returns at the same phase.
    task automatic cycle(input string tag, input logic v, input logic [c_W-1:0] ins,
                         input logic st, input logic fl);
        instr_valid = v; instr = ins; stall = st; flush = fl;
        #3;
        chk({tag, "_out"}, w_obs, {m_cur.valid, m_cur.b, m_cur.alu, m_cur.halted, m_cur.illegal});
        chk({tag, "_rdy"}, {19'b0, instr_ready}, {19'b0, model_ready(st, fl)});
        @(posedge clk);
        model_edge(v, ins, st, fl);
        #1;
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b1;
        #1;
        m_q.delete(); m_cur = '0; m_halting = 1'b0;
        chk(tag, w_obs, 20'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [c_W-1:0] r_ins;
        logic [3:0] r_op;
        m_cur = '0; m_halting = 1'b0;
        @(posedge clk);
        #1;
        chk("reset", w_obs, 20'h0);
        rst = 1'b0;

        cycle("add_acc", 1'b1, 16'h0123, 1'b0, 1'b0);
        cycle("add_v",   1'b0, 16'h0000, 1'b0, 1'b0);
        cycle("add_end", 1'b0, 16'h0000, 1'b0, 1'b0);

        cycle("call_acc", 1'b1, 16'hD000, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cycle("call_seq", 1'b1, 16'h1111, 1'b0, 1'b0);

        cycle("ret_acc", 1'b1, 16'hE000, 1'b0, 1'b0);
        cycle("ret_m1",  1'b0, 16'h0000, 1'b0, 1'b0);
        cycle("ret_st",  1'b1, 16'h2222, 1'b1, 1'b0);
        cycle("ret_st",  1'b1, 16'h2222, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) cycle("ret_seq", 1'b0, 16'h0000, 1'b0, 1'b0);

        cycle("cfl_acc", 1'b1, 16'hD000, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("cfl_mem", 1'b0, 16'h0000, 1'b0, 1'b0);
        cycle("cfl_wb",  1'b0, 16'h0000, 1'b0, 1'b1);
        cycle("cfl_idle", 1'b0, 16'h0000, 1'b0, 1'b0);

        cycle("lw",  1'b1, 16'h8123, 1'b0, 1'b0);
        cycle("sw",  1'b1, 16'h9123, 1'b0, 1'b0);
        cycle("lhb", 1'b1, 16'hA0FF, 1'b0, 1'b0);
        cycle("llb", 1'b1, 16'hB0FF, 1'b0, 1'b0);
        cycle("b",   1'b1, 16'hC456, 1'b0, 1'b0);
        cycle("inc", 1'b1, 16'h4001, 1'b0, 1'b0);
        cycle("sub", 1'b1, 16'h1001, 1'b0, 1'b0);
        cycle("idle", 1'b0, 16'h0000, 1'b0, 1'b0);

        cycle("ill_acc", 1'b1, 16'hF001, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("ill_seq", 1'b0, 16'h0000, 1'b0, 1'b0);
        do_reset("ill_rst");

        cycle("halt_acc", 1'b1, 16'hFFFF, 1'b0, 1'b0);
        cycle("halt_v",   1'b1, 16'h0123, 1'b0, 1'b1);
        cycle("halt_st",  1'b1, 16'h0123, 1'b1, 1'b0);
        cycle("halt_fl",  1'b1, 16'hD000, 1'b0, 1'b1);
        cycle("halt_ign", 1'b1, 16'h0123, 1'b0, 1'b0);
        do_reset("halt_rst");
        cycle("post_rst", 1'b0, 16'h0000, 1'b0, 1'b0);

        for (int n = 0; n < 3000; n++) begin
            r_op  = 4'($urandom_range(0, 15));
            r_ins = {r_op, 12'($urandom)};
            if (r_op == 4'hF && ($urandom % 3 == 0)) r_ins = 16'hFFFF;
            if ((m_halting && ($urandom % 6 == 0)) || ($urandom % 400 == 0))
                do_reset("rnd_rst");
            cycle("rnd", 1'($urandom % 4 != 0), r_ins,
                  1'($urandom % 7 == 0), 1'($urandom % 13 == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ctrl_seq_unit.md
CTRL_SEQ_UNIT -- requirements
Module: ctrl_seq_unit

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction width (>=16); opcode = instr[INSTR_W-1 -: 4].
REQ-002 SHALL have parameter MEM_LAT, default 1, cycles in the memory phase of CALL/RET (legal 1..4).
REQ-003 SHALL have ports, in this order:
- clk  in  1  clock.
- rst  in  1  reset; one clock, asynchronous, active-high.
- instr_valid  in  1  instr holds a valid instruction.
- instr  in  INSTR_W  instruction word.
- instr_ready  out  1  unit accepts instr this cycle.
- stall  in  1  downstream hold.
- flush  in  1  discard current operation.
- ctrl_valid  out  1  control bundle valid.
- data_reg, stack_reg, call, rtrn, branch, mem_to_reg, alu_src, sign_ext_sel, reg_rt_src, RegWrite, MemWrite, MemRead, load_half, half_spec  out  1 each  registered control bundle.
- alu_op  out  3  ALU operation.
- halted  out  1  sticky halt.
- illegal_op  out  1  illegal-opcode flag.

Function
REQ-004 SHALL implement FSM states IDLE, MEM, WB, HALTED.
REQ-005 SHALL drive instr_ready = (state==IDLE) & !stall & !halted & !flush.
REQ-006 SHALL accept an instruction on instr_valid & instr_ready; ctrl_valid SHALL rise the next cycle (latency 1).
REQ-007 SHALL drive every bundle output and alu_op to 0 whenever ctrl_valid=0; no X or Z is ever driven.
REQ-008 SHALL decode single-cycle ops (one ctrl_valid cycle):
- 0000-0111: alu_op=opcode[2:0], RegWrite=1; INC (0100) also alu_src=1.
- LW 1000: data_reg, mem_to_reg, alu_src, sign_ext_sel, RegWrite, MemRead=1; alu_op=000.
- SW 1001: data_reg, alu_src, sign_ext_sel, reg_rt_src, MemWrite=1; alu_op=000.
- LHB 1010 / LLB 1011: reg_rt_src, RegWrite, load_half=1; half_spec=0 for LHB, 1 for LLB; alu_op=opcode[2:0].
- B 1100: branch, sign_ext_sel=1; alu_op=000.
REQ-009 SHALL run CALL (1101) as IDLE->MEM for MEM_LAT cycles (stack_reg, MemWrite=1), then WB for 1 cycle (stack_reg, call, RegWrite=1), then IDLE.
REQ-010 SHALL run RET (1110) the same way, with MemRead=1 in MEM and rtrn, RegWrite, stack_reg=1 in WB.
REQ-011 SHALL hold ctrl_valid=1 across all MEM and WB cycles; alu_op=000 throughout.
REQ-012 SHALL use a 2-bit down-counter loaded with MEM_LAT-1 on entering MEM, leaving MEM when it reaches 0.
REQ-013 SHALL, while stall=1, freeze the state, counter and all outputs, and accept nothing.
REQ-014 SHALL, on flush=1 (which overrides stall), zero ctrl_valid and the bundle next cycle and return to IDLE, except from HALTED.
REQ-015 SHALL treat instr all ones as HALT: one ctrl_valid cycle with an all-zero bundle, halted=1 next cycle, then HALTED until reset.
REQ-016 SHALL treat opcode 1111 not all ones as illegal: one ctrl_valid cycle with an all-zero bundle and illegal_op=1 for that cycle.
REQ-017 SHALL ignore instr_valid in HALTED; flush and stall have no effect in HALTED.

Reset
REQ-018 SHALL on rst force state=IDLE, counter=0, ctrl_valid=0, bundle=0, alu_op=000, halted=0, illegal_op=0, asynchronously, including mid-sequence.
REQ-019 SHALL assert instr_ready=1 in the first cycle after rst deasserts, provided stall=0 and flush=0.

Configuration
REQ-020 SHALL, with CTRL_SEQ_ILLEGAL_TRAP_EN defined, make illegal_op sticky and enter HALTED on an illegal opcode (halted=1 the cycle after ctrl_valid); without it, illegal_op is a one-cycle pulse and the unit returns to IDLE.

Verification
REQ-021 SHALL cover: ADD 0x0123 accepted -> next cycle ctrl_valid=1, RegWrite=1, alu_op=000, single cycle.
REQ-022 SHALL cover: CALL 0xD000, MEM_LAT=3 -> 3 cycles MemWrite=1 and stack_reg=1, then 1 cycle call=1 and RegWrite=1; instr_ready=0 for those 4 cycles.
REQ-023 SHALL cover: RET with stall=1 asserted for 2 cycles mid-MEM -> outputs frozen for those 2 cycles, total sequence length extends by 2.
REQ-024 SHALL cover: flush during WB of CALL -> ctrl_valid=0 next cycle, state IDLE, instr_ready=1.
REQ-025 SHALL cover: instr 0xFFFF -> halted=1 and stays 1; subsequent instr_valid ignored; rst clears halted to 0.
REQ-026 SHALL cover: instr 0xF001 -> illegal_op=1 for one cycle with an all-zero bundle; with CTRL_SEQ_ILLEGAL_TRAP_EN defined, halted=1 and illegal_op stays 1.
